// File: rtl/rr_arbiter_4_amisha_pkg.sv
// Shared types and widths for the four-requester round-robin arbiter.
// Imported by the arbiter top and its grant decoder.
package rr_arbiter_pkg_amisha;

    localparam int N_REQ = 4;
    localparam int IDX_W = 2;
    localparam int CNT_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

endpackage

// File: rtl/rr_arbiter_4_amisha_decoder.sv
// 2-to-4 enable decoder: turns the registered grant index/valid pair into a one-hot grant.
// Purely combinational, so the one-hot grant has no path from req or done.
module decoder_2_4_case_Amisha
    import rr_arbiter_pkg_amisha::*;
(
    input  logic [IDX_W-1:0] a_amisha,
    input  logic             en_amisha,
    output logic [N_REQ-1:0] y_amisha
);

    always_comb begin
        y_amisha = '0;
        if (en_amisha) begin
            case (a_amisha)
                2'd0:    y_amisha = 4'b0001;
                2'd1:    y_amisha = 4'b0010;
                2'd2:    y_amisha = 4'b0100;
                2'd3:    y_amisha = 4'b1000;
                default: y_amisha = '0;
            endcase
        end
    end

endmodule

// File: rtl/rr_arbiter_4_amisha.sv
// Four-requester round-robin arbiter with owner release and a hold timeout.
// Grant index/valid are registered; the one-hot grant is decoded from them.
module rr_arbiter_4_amisha
    import rr_arbiter_pkg_amisha::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic             clk_amisha,
    input  logic             rst_n_amisha,
    input  logic [N_REQ-1:0] req_amisha,
    input  logic [N_REQ-1:0] done_amisha,
    output logic [N_REQ-1:0] gnt_amisha,
    output logic [IDX_W-1:0] gnt_idx_amisha,
    output logic             gnt_vld_amisha,
    output logic             timeout_amisha
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_e           state_q,   state_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic             gnt_vld_q, gnt_vld_d;
    logic             timeout_q, timeout_d;
    logic [IDX_W-1:0] ptr_q,     ptr_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;

    logic [IDX_W-1:0] winner;
    logic             owner_release;

    // Scan ptr+1 .. ptr+4 (mod 4); the 2-bit add wraps, so ptr+4 is ptr itself.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [N_REQ-1:0] req,
        input logic [IDX_W-1:0] ptr
    );
        logic [IDX_W-1:0] cand;
        logic [IDX_W-1:0] win;
        logic             found;
        win   = ptr;
        found = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = ptr + IDX_W'(i);
            if (!found && req[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
        return win;
    endfunction

    assign winner        = rr_pick(req_amisha, ptr_q);
    assign owner_release = done_amisha[gnt_idx_q] || !req_amisha[gnt_idx_q];

    always_comb begin
        state_d   = state_q;
        gnt_idx_d = gnt_idx_q;
        gnt_vld_d = gnt_vld_q;
        timeout_d = 1'b0;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (|req_amisha) begin
                    gnt_idx_d = winner;
                    gnt_vld_d = 1'b1;
                    ptr_d     = winner;
                    cnt_d     = '0;
                    state_d   = GRANT;
                end
            end
            GRANT: begin
                // Owner release wins over a timeout landing on the same cycle.
                if (owner_release) begin
                    gnt_vld_d = 1'b0;
                    state_d   = IDLE;
                end else if (cnt_q == HOLD_LAST) begin
                    gnt_vld_d = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                gnt_vld_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_amisha) begin
        if (!rst_n_amisha) begin
            state_q   <= IDLE;
            gnt_idx_q <= '0;
            gnt_vld_q <= 1'b0;
            timeout_q <= 1'b0;
            ptr_q     <= 2'd3;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_idx_q <= gnt_idx_d;
            gnt_vld_q <= gnt_vld_d;
            timeout_q <= timeout_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign gnt_idx_amisha = gnt_idx_q;
    assign gnt_vld_amisha = gnt_vld_q;
    assign timeout_amisha = timeout_q;

    decoder_2_4_case_Amisha u_dec (
        .a_amisha  (gnt_idx_q),
        .en_amisha (gnt_vld_q),
        .y_amisha  (gnt_amisha)
    );

endmodule
